// File: rtl/change_dispenser.sv
// Change dispenser: pays a change request out as 5/10 coins over a valid/ack bus,
// greedily from two saturating hopper inventories. Optional ack timeout: CHANGE_TIMEOUT_EN.
module change_dispenser #(
   parameter int AMT_W      = 4,
   parameter int INV_W      = 8,
   parameter int INV5_INIT  = 10,
   parameter int INV10_INIT = 10,
   parameter int TIMEOUT    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req,
   input  logic [AMT_W-1:0] req_amount,
   input  logic             refill_5,
   input  logic             refill_10,
   output logic [1:0]       coin,
   output logic             coin_valid,
   input  logic             coin_ack,
   output logic             busy,
   output logic             done,
   output logic             short,
   output logic [AMT_W-1:0] remaining,
   output logic [INV_W-1:0] inv5,
   output logic [INV_W-1:0] inv10
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SELECT = 2'd1,
      ST_SEND   = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [1:0]       COIN_NONE = 2'b00;
   localparam logic [1:0]       COIN_5    = 2'b01;
   localparam logic [1:0]       COIN_10   = 2'b10;
   localparam logic [AMT_W-1:0] AMT_ONE   = AMT_W'(1);
   localparam logic [AMT_W-1:0] AMT_TWO   = AMT_W'(2);
   localparam logic [INV_W-1:0] INV_ONE   = INV_W'(1);
   localparam logic [INV_W-1:0] INV_MAX   = '1;

   state_t           state_q, state_d;
   logic [1:0]       coin_q, coin_d;
   logic [AMT_W-1:0] remaining_q, remaining_d;
   logic [INV_W-1:0] inv5_q, inv5_d;
   logic [INV_W-1:0] inv10_q, inv10_d;
   logic             dec5, dec10;
   logic             timeoutHit;

`ifdef CHANGE_TIMEOUT_EN
   localparam int             TMO_W    = $clog2(TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   logic [TMO_W-1:0] tmoCount_q, tmoCount_d;

   // Counts unacknowledged SEND cycles; zero outside SEND, so it restarts on every entry.
   always_comb begin
      tmoCount_d = '0;
      if (state_q == ST_SEND && !coin_ack) begin
         tmoCount_d = tmoCount_q + TMO_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tmoCount_q <= '0;
      end else begin
         tmoCount_q <= tmoCount_d;
      end
   end

   assign timeoutHit = (state_q == ST_SEND) && !coin_ack && (tmoCount_q == TMO_LAST);
`else
   assign timeoutHit = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      coin_d      = coin_q;
      remaining_d = remaining_q;
      dec5        = 1'b0;
      dec10       = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (req) begin
               remaining_d = req_amount;
               state_d     = (req_amount == '0) ? ST_DONE : ST_SELECT;
            end
         end
         ST_SELECT: begin
            // A 10 is only picked with at least 2 units owed, so remaining cannot underflow.
            if (remaining_q >= AMT_TWO && inv10_q != '0) begin
               coin_d  = COIN_10;
               state_d = ST_SEND;
            end else if (remaining_q >= AMT_ONE && inv5_q != '0) begin
               coin_d  = COIN_5;
               state_d = ST_SEND;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_SEND: begin
            if (coin_ack) begin
               if (coin_q == COIN_10) begin
                  dec10       = 1'b1;
                  remaining_d = remaining_q - AMT_TWO;
               end else begin
                  dec5        = 1'b1;
                  remaining_d = remaining_q - AMT_ONE;
               end
               coin_d  = COIN_NONE;
               state_d = (remaining_d == '0) ? ST_DONE : ST_SELECT;
            end else if (timeoutHit) begin
               coin_d  = COIN_NONE;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Saturating inventories; a refill and a payout of the same coin cancel out.
   always_comb begin
      inv5_d  = inv5_q;
      inv10_d = inv10_q;
      if (refill_5 && !dec5 && inv5_q != INV_MAX) begin
         inv5_d = inv5_q + INV_ONE;
      end else if (dec5 && !refill_5 && inv5_q != '0) begin
         inv5_d = inv5_q - INV_ONE;
      end
      if (refill_10 && !dec10 && inv10_q != INV_MAX) begin
         inv10_d = inv10_q + INV_ONE;
      end else if (dec10 && !refill_10 && inv10_q != '0) begin
         inv10_d = inv10_q - INV_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         coin_q      <= COIN_NONE;
         remaining_q <= '0;
         inv5_q      <= INV_W'(INV5_INIT);
         inv10_q     <= INV_W'(INV10_INIT);
      end else begin
         state_q     <= state_d;
         coin_q      <= coin_d;
         remaining_q <= remaining_d;
         inv5_q      <= inv5_d;
         inv10_q     <= inv10_d;
      end
   end

   assign coin       = coin_q;
   assign coin_valid = (state_q == ST_SEND);
   assign busy       = (state_q != ST_IDLE);
   assign done       = (state_q == ST_DONE);
   assign short      = (state_q == ST_DONE) && (remaining_q != '0);
   assign remaining  = remaining_q;
   assign inv5       = inv5_q;
   assign inv10      = inv10_q;

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Coin-return transmitter for the vending datapath. Accepts a change request from the vending controller and pays it out as a sequence of coins on a 2-bit coin bus. The bus uses the same encoding the vending machine consumes: 01 = 5, 10 = 10. The block selects coins greedily from two internal hopper inventories and hands each coin to the hopper driver over a valid/ack handshake.

## Interface
Parameters:
- AMT_W, 4: width of the change amount, in units of 5.
- INV_W, 8: width of each hopper inventory counter.
- INV5_INIT, 10: count of 5-coins after reset.
- INV10_INIT, 10: count of 10-coins after reset.
- TIMEOUT, 16: ack timeout in cycles; used only with the macro.

Ports:
- clk, in, 1: single clock, rising edge.
- reset, in, 1: synchronous, active-high.
- req, in, 1: change request strobe; sampled only in IDLE.
- req_amount, in, AMT_W: change owed, in units of 5.
- refill_5, in, 1: adds one 5-coin to inventory per cycle high.
- refill_10, in, 1: adds one 10-coin to inventory per cycle high.
- coin, out, 2: coin being dispensed; 00 when idle; 11 never driven.
- coin_valid, out, 1: coin is presented to the hopper.
- coin_ack, in, 1: hopper accepted the coin.
- busy, out, 1: high in every state except IDLE.
- done, out, 1: one-cycle pulse at the end of a request.
- short, out, 1: one-cycle pulse with done when change was not fully paid.
- remaining, out, AMT_W: units still owed.
- inv5, out, INV_W: current 5-coin inventory.
- inv10, out, INV_W: current 10-coin inventory.

## Operation
- States: IDLE, SELECT, SEND, DONE. Encoding is 2 bits and internal only.
- IDLE, req=1:
  - remaining <= req_amount.
  - If req_amount == 0, go to DONE; otherwise go to SELECT.
- SELECT, greedy choice:
  - If remaining >= 2 and inv10 > 0: coin <= 10, go to SEND.
  - Else if remaining >= 1 and inv5 > 0: coin <= 01, go to SEND.
  - Else: go to DONE.
- SEND: coin_valid=1 and coin is held stable until coin_ack is sampled high. On ack:
  - Decrement the matching inventory.
  - remaining <= remaining - 2 for a 10-coin, or remaining - 1 for a 5-coin.
  - Next state is DONE if the new remaining is 0; otherwise SELECT.
- DONE (one cycle):
  - done=1, and short=(remaining != 0).
  - coin=00; remaining holds its value until the next accepted req.
  - Then go to IDLE.
- Odd amounts with 10-coins only: pay 10s down to 1 unit, then short.
- Arithmetic rules:
  - remaining never underflows, because 10 is chosen only when remaining >= 2.
  - Inventory updates saturate at 0 and at 2^INV_W-1.
  - A refill in the same cycle as a decrement of that denomination gives a net change of 0.
- Refills are accepted in every state. An inventory that becomes non-zero is seen on the next SELECT.
- req while busy=1 is ignored and not queued.

## Timing
- Reset values:
  - State IDLE.
  - coin=00, coin_valid=0, busy=0, done=0, short=0, remaining=0.
  - inv5=INV5_INIT, inv10=INV10_INIT.
- req sampled high at edge t: busy=1 after t. SELECT occupies t..t+1, and coin_valid rises after edge t+1.
- Ack in the first valid cycle: one coin costs 2 cycles (SELECT + SEND).
- After the last ack edge, done=1 for exactly one cycle and busy=1 during it. IDLE follows.
- A zero amount gives done one cycle after the req edge, with short=0.
- coin_valid falls on the edge after the ack. It never stays high into SELECT.
- coin_ack while coin_valid=0 is ignored.
- Reset mid-operation:
  - Any in-flight coin is abandoned and no done is produced.
  - All outputs and inventories return to their reset values.

## Configuration
- CHANGE_TIMEOUT_EN defined:
  - A cycle counter runs in SEND and clears on entry.
  - If TIMEOUT cycles pass with no ack, coin_valid drops and the FSM goes to DONE with short=1.
  - The coin is not decremented from inventory.
- CHANGE_TIMEOUT_EN undefined: SEND waits indefinitely for ack. No timeout logic is synthesized.

## Test plan
- Reset then idle: coin=00, busy=0, remaining=0, inv5=10, inv10=10. A req with req_amount=0 gives done=1 and short=0 one cycle later.
- req_amount=3, ack tied high: coins 10 then 01, done with short=0, inv10=9, inv5=9. Total latency is 5 cycles from the req edge to done.
- INV10_INIT=0, req_amount=4: four 01 coins, inv5=6, short=0.
- inv5=0, inv10=1, req_amount=3: one 10 coin, then done with short=1 and remaining=1.
- Ack delayed 3 cycles: coin and coin_valid are held stable. A req mid-transfer is ignored. refill_10 on the ack cycle leaves inv10 unchanged.
- With CHANGE_TIMEOUT_EN and TIMEOUT=16, ack held low: done and short=1 after 16 SEND cycles, inventory unchanged. Reset asserted mid-SEND in a separate run returns all outputs to their reset values.
